// File: rtl/ghost_pkg.sv
// Shared ghost-AI definitions: direction encodings, index helpers and the
// decision FSM state type. The direction values match the ghost mover.
package ghost_pkg;

  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [1:0] IDX_UP    = 2'd0;
  localparam logic [1:0] IDX_DOWN  = 2'd1;
  localparam logic [1:0] IDX_LEFT  = 2'd2;
  localparam logic [1:0] IDX_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } ghost_state_t;

  // Reverse of a one-hot direction; stop has no reverse.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_STOP;
    endcase
  endfunction

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Only meaningful for a non-stop direction; stop maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] d);
    case (d)
      DIR_DOWN:  return IDX_DOWN;
      DIR_LEFT:  return IDX_LEFT;
      DIR_RIGHT: return IDX_RIGHT;
      default:   return IDX_UP;
    endcase
  endfunction

endpackage

// File: rtl/ghost_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) shared by the ghost-AI blocks.
// A zero seed would lock the register up, so it is replaced by 1.
module ghost_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  // Shift left, feeding the tap XOR into bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED_EFF;
    end else if (en) begin
      value <= {value[14:0], feedback};
    end
  end

endmodule

// File: rtl/ghost_dir_ctrl.sv
// Ghost direction controller. On each tick it probes the neighbouring tiles
// through the maze wall ROM, starting at a pseudo-random candidate, avoids
// reversing unless boxed in, and issues a one-hot direction to the mover.
//
// Handshakes: q_valid is a one-cycle query strobe with q_x/q_y stable in
// that cycle; the ROM returns q_wall in the following cycle, with no
// backpressure. dir_valid is a one-cycle pulse in the cycle dir takes its
// new value; the mover cannot stall it.
module ghost_dir_ctrl
  import ghost_pkg::*;
#(
  parameter int          X_W       = 6,
  parameter int          Y_W       = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [X_W-1:0] ghost_x,
  input  logic [Y_W-1:0] ghost_y,
  output logic [X_W-1:0] q_x,
  output logic [Y_W-1:0] q_y,
  output logic           q_valid,
  input  logic           q_wall,
  output logic [3:0]     dir,
  output logic           dir_valid,
  output logic           busy
);

  ghost_state_t   state;
  logic [X_W-1:0] lat_x;
  logic [Y_W-1:0] lat_y;
  logic [1:0]     start;
  logic [1:0]     cnt;
  logic           pass;
  logic [15:0]    lfsr;
  logic           unused_lfsr_hi;

  logic [3:0]     rev_oh;
  logic           has_rev;
  logic [1:0]     rev_idx;
  logic [1:0]     cur_k;
  logic [1:0]     seq_k;

  ghost_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr)
  );

  // Upper LFSR bits are left for other ghost-AI consumers.
  assign unused_lfsr_hi = ^lfsr[15:2];

  assign rev_oh  = opposite(dir);
  assign has_rev = |rev_oh;
  assign rev_idx = onehot_to_idx(rev_oh);
  // Candidate under test: rotating order in pass 0, the reverse in pass 1.
  assign cur_k   = pass ? rev_idx : start + cnt;
  // Next pass-0 candidate after the current one.
  assign seq_k   = start + cnt + 2'd1;
  assign busy    = (state != IDLE);

  function automatic logic is_skip(input logic [1:0] k, input logic p);
    return !p && has_rev && (k == rev_idx);
  endfunction

  function automatic logic [X_W-1:0] step_x(input logic [1:0] k, input logic [X_W-1:0] x);
    case (k)
      IDX_LEFT:  return x - X_W'(1);
      IDX_RIGHT: return x + X_W'(1);
      default:   return x;
    endcase
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [1:0] k, input logic [Y_W-1:0] y);
    case (k)
      IDX_UP:   return y - Y_W'(1);
      IDX_DOWN: return y + Y_W'(1);
      default:  return y;
    endcase
  endfunction

  // Decision FSM. Query strobes are loaded on the edge that enters a
  // non-skipping QUERY cycle, and dir/dir_valid on the edge entering ISSUE,
  // so every output is a register and q_valid lines up with QUERY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= DIR_STOP;
      dir_valid <= 1'b0;
      q_valid   <= 1'b0;
      q_x       <= '0;
      q_y       <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      start     <= 2'd0;
      cnt       <= 2'd0;
      pass      <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      q_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            lat_x <= ghost_x;
            lat_y <= ghost_y;
            start <= lfsr[1:0];
            cnt   <= 2'd0;
            pass  <= 1'b0;
            state <= QUERY;
            if (!is_skip(lfsr[1:0], 1'b0)) begin
              q_valid <= 1'b1;
              q_x     <= step_x(lfsr[1:0], ghost_x);
              q_y     <= step_y(lfsr[1:0], ghost_y);
            end
          end
        end
        QUERY: begin
          if (is_skip(cur_k, pass)) begin
            // Only one candidate is the reverse, so the follow-up never skips.
            cnt     <= cnt + 2'd1;
            q_valid <= 1'b1;
            if (cnt == 2'd3) begin
              pass <= 1'b1;
              q_x  <= step_x(rev_idx, lat_x);
              q_y  <= step_y(rev_idx, lat_y);
            end else begin
              q_x  <= step_x(seq_k, lat_x);
              q_y  <= step_y(seq_k, lat_y);
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!q_wall) begin
            dir       <= idx_to_onehot(cur_k);
            dir_valid <= 1'b1;
            state     <= ISSUE;
          end else if (!pass && cnt != 2'd3) begin
            cnt   <= cnt + 2'd1;
            state <= QUERY;
            if (!is_skip(seq_k, 1'b0)) begin
              q_valid <= 1'b1;
              q_x     <= step_x(seq_k, lat_x);
              q_y     <= step_y(seq_k, lat_y);
            end
          end else if (!pass && has_rev) begin
            pass    <= 1'b1;
            state   <= QUERY;
            q_valid <= 1'b1;
            q_x     <= step_x(rev_idx, lat_x);
            q_y     <= step_y(rev_idx, lat_y);
          end else begin
            dir       <= DIR_STOP;
            dir_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_dir_ctrl.sv
// Bench for ghost_dir_ctrl: wall-ROM model, decision reference model,
// directed table, busy/reset sequences and randomized decisions.
module tb_ghost_dir_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tick    = 1'b0;
  logic [5:0] ghost_x = '0;
  logic [5:0] ghost_y = '0;
  logic [5:0] q_x;
  logic [5:0] q_y;
  logic       q_valid;
  logic       q_wall  = 1'b0;
  logic [3:0] dir;
  logic       dir_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  m_dir = 4'b0000;
  logic [5:0]  cur_x = '0;
  logic [5:0]  cur_y = '0;
  logic [3:0]  nb_wall = 4'b1111;
  // {query cycle after tick, x, y}
  logic [19:0] exp_q[$];

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [3:0] pre;
    logic [3:0] walls;
    logic [3:0] exp_dir;
    int         lat;
    int         nq;
  } vec_t;

  vec_t vecs[7];

  logic [3:0] gd;
  int         gl;
  int         gn;

  ghost_dir_ctrl #(.X_W(6), .Y_W(6), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .ghost_x   (ghost_x),
    .ghost_y   (ghost_y),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_valid   (q_valid),
    .q_wall    (q_wall),
    .dir       (dir),
    .dir_valid (dir_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting every non-reset cycle.
  always @(posedge clk) begin
    m_lfsr <= rst ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [1:0] oh_idx(input logic [3:0] d);
    case (d)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Neighbour tile with modulo-64 wrap.
  function automatic logic [11:0] nb(input logic [1:0] k, input logic [5:0] x, input logic [5:0] y);
    case (k)
      2'd0:    return {x, y - 6'd1};
      2'd1:    return {x, y + 6'd1};
      2'd2:    return {x - 6'd1, y};
      default: return {x + 6'd1, y};
    endcase
  endfunction

  function automatic logic rom_wall(input logic [5:0] x, input logic [5:0] y);
    for (int k = 0; k < 4; k++) begin
      if (nb(2'(k), cur_x, cur_y) == {x, y}) return nb_wall[k];
    end
    return 1'b1;
  endfunction

  // Wall ROM: answer one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    q_wall <= q_valid ? rom_wall(q_x, q_y) : 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Decision model: walk candidates from the start index, never reversing
  // unless everything else is walled; each query costs 2 cycles, a skipped
  // reverse 1 cycle, and the result shows 1 cycle after the last step.
  task automatic model(input logic [1:0] st, output logic [3:0] res, output int lat);
    int         cyc;
    logic       found;
    logic       has_rev;
    logic [1:0] rev;
    logic [1:0] k;
    cyc = 0;
    found = 1'b0;
    has_rev = (m_dir != 4'b0000);
    rev = oh_idx(m_dir) ^ 2'd1;
    res = 4'b0000;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (!found) begin
        k = st + 2'(c);
        if (has_rev && k == rev) begin
          cyc += 1;
        end else begin
          exp_q.push_back({8'(cyc + 1), nb(k, cur_x, cur_y)});
          cyc += 2;
          if (!nb_wall[k]) begin
            found = 1'b1;
            res = 4'b0001 << k;
          end
        end
      end
    end
    if (!found && has_rev) begin
      exp_q.push_back({8'(cyc + 1), nb(rev, cur_x, cur_y)});
      cyc += 2;
      res = nb_wall[rev] ? 4'b0000 : (4'b0001 << rev);
    end
    lat = cyc + 1;
  endtask

  task automatic run_decision(input logic [5:0] x, input logic [5:0] y, input logic [3:0] walls,
                              input int extra_tick, output logic [3:0] got_dir,
                              output int got_lat, output int got_nq);
    logic [3:0]  exp_dir;
    logic [3:0]  old_dir;
    int          exp_lat;
    int          dv_cnt;
    int          bad_busy;
    int          early;
    int          consec;
    int          extra_q;
    logic        prev_q;
    logic [19:0] e;
    @(negedge clk);
    cur_x = x;
    cur_y = y;
    nb_wall = walls;
    ghost_x = x;
    ghost_y = y;
    tick = 1'b1;
    model(m_lfsr[1:0], exp_dir, exp_lat);
    old_dir = m_dir;
    dv_cnt = 0; bad_busy = 0; early = 0; consec = 0; extra_q = 0; prev_q = 1'b0;
    got_dir = 4'b0000; got_lat = 0; got_nq = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      tick = (n == extra_tick);
      ghost_x = 6'($urandom);
      ghost_y = 6'($urandom);
      if (busy !== (n <= exp_lat)) bad_busy++;
      if (q_valid) begin
        got_nq++;
        if (prev_q) consec++;
        if (exp_q.size() == 0) extra_q++;
        else begin
          e = exp_q.pop_front();
          check("query_cycle_xy", {12'd0, 8'(n), q_x, q_y}, {12'd0, e});
        end
      end
      prev_q = q_valid;
      if (dir_valid) begin
        dv_cnt++;
        if (dv_cnt == 1) begin
          got_dir = dir;
          got_lat = n;
        end
      end else if (dv_cnt == 0 && dir !== old_dir) begin
        early++;
      end
    end
    tick = 1'b0;
    check("missed_queries", exp_q.size(), 0);
    check("extra_queries", extra_q, 0);
    check("dir_valid_count", dv_cnt, 1);
    check("latency", got_lat, exp_lat);
    check("dir", {28'd0, got_dir}, {28'd0, exp_dir});
    check("dir_early_change", early, 0);
    check("busy_profile", bad_busy, 0);
    check("q_valid_back_to_back", consec, 0);
    m_dir = exp_dir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_x", q_x, 0);
    check("rst_q_y", q_y, 0);
    check("rst_dir", dir, 0);
    check("rst_dir_valid", dir_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lfsr", dut.u_lfsr.value, 16'hACE1);
    rst = 1'b0;
    m_dir = 4'b0000;
  endtask

  // Force the controller's current direction: open only that neighbour.
  task automatic set_dir(input logic [3:0] d, input logic [5:0] x, input logic [5:0] y);
    logic [3:0] rd;
    int         rl;
    int         rn;
    if (d == 4'b0000) do_reset();
    else run_decision(x, y, ~d, 0, rd, rl, rn);
  endtask

  initial begin : main
    logic [3:0]  rd;
    int          rl;
    int          wait_cyc;
    int          stray;
    logic [19:0] e;

    vecs[0] = '{6'd8,  6'd8,  4'b0001, 4'b1101, 4'b0010, 10, 4};  // dead end, reverse DOWN
    vecs[1] = '{6'd8,  6'd8,  4'b0100, 4'b1111, 4'b0000, 10, 4};  // enclosed heading LEFT
    vecs[2] = '{6'd8,  6'd8,  4'b0000, 4'b1111, 4'b0000, 9,  4};  // enclosed, stopped
    vecs[3] = '{6'd0,  6'd0,  4'b0000, 4'b1011, 4'b0100, 0,  0};  // wrap to x=63
    vecs[4] = '{6'd0,  6'd0,  4'b0000, 4'b1110, 4'b0001, 0,  0};  // wrap to y=63
    vecs[5] = '{6'd30, 6'd5,  4'b1000, 4'b1011, 4'b0100, 10, 4};  // dead end, reverse LEFT
    vecs[6] = '{6'd63, 6'd63, 4'b0010, 4'b1111, 4'b0000, 10, 4};  // enclosed at far corner

    do_reset();

    // Open cell from reset: one query, result after 3 cycles.
    run_decision(6'd8, 6'd8, 4'b0000, 0, gd, gl, gn);
    check("open_latency", gl, 3);
    check("open_queries", gn, 1);

    for (int i = 0; i < 7; i++) begin
      set_dir(vecs[i].pre, vecs[i].x, vecs[i].y);
      run_decision(vecs[i].x, vecs[i].y, vecs[i].walls, 0, gd, gl, gn);
      check("vec_dir", {28'd0, gd}, {28'd0, vecs[i].exp_dir});
      if (vecs[i].lat != 0) begin
        check("vec_latency", gl, vecs[i].lat);
        check("vec_queries", gn, vecs[i].nq);
      end
    end

    // Ticks while busy are dropped (WAIT and ISSUE cycles).
    run_decision(6'd20, 6'd30, 4'b0000, 2, gd, gl, gn);
    run_decision(6'd21, 6'd31, 4'b0000, 3, gd, gl, gn);

    // Reset while waiting on the ROM abandons the decision.
    set_dir(4'b1000, 6'd8, 6'd8);
    @(negedge clk);
    cur_x = 6'd8; cur_y = 6'd8; nb_wall = 4'b0000;
    ghost_x = 6'd8; ghost_y = 6'd8; tick = 1'b1;
    model(m_lfsr[1:0], rd, rl);
    e = exp_q[0];
    wait_cyc = int'(e[19:12]) + 1;
    for (int n = 1; n <= wait_cyc; n++) begin
      @(negedge clk);
      tick = 1'b0;
    end
    check("rw_busy_in_wait", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_idle", busy, 0);
    check("rw_dir_valid", dir_valid, 0);
    check("rw_q_valid", q_valid, 0);
    check("rw_dir", dir, 0);
    m_dir = 4'b0000;
    exp_q.delete();
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (dir_valid || q_valid) stray++;
    end
    check("rw_stray_activity", stray, 0);

    // Randomized decisions, walls biased towards closed.
    for (int i = 0; i < 40; i++) begin
      run_decision(6'($urandom), 6'($urandom), 4'($urandom) | 4'($urandom), 0, gd, gl, gn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghost_dir_ctrl.md
# ghost_dir_ctrl

Decides the next move direction for one ghost and issues it as a one-hot command to the ghost movement block, which applies it to `xpos`/`ypos`. On each move tick it probes neighbouring tiles through the maze wall-ROM read port, starting from a pseudo-random candidate. It refuses to reverse the current direction unless it is at a dead end. One instance sits beside each ghost mover, between the game-tick generator and the maze ROM.

## Interface
Parameters:
- `X_W`, 6: tile x-coordinate width.
- `Y_W`, 6: tile y-coordinate width.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; 0 is replaced by 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  in  1  move-step strobe, one cycle.
- `ghost_x`  in  X_W  current ghost tile x.
- `ghost_y`  in  Y_W  current ghost tile y.
- `q_x`  out  X_W  wall query tile x.
- `q_y`  out  Y_W  wall query tile y.
- `q_valid`  out  1  wall query strobe.
- `q_wall`  in  1  wall flag; valid exactly 1 cycle after `q_valid`.
- `dir`  out  4  one-hot direction: UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000, 0 = stop.
- `dir_valid`  out  1  one-cycle pulse when `dir` updates.
- `busy`  out  1  high in any state except IDLE.

## Operation
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Shifts every non-reset cycle.
- **Candidate indices:** 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- **Neighbour coordinates:** UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1. Modulo 2^W wrap provides the tunnel.
- **Reverse direction:** opposite of registered `dir`. When `dir` = 0 there is no reverse.
- **FSM states:**
  - IDLE: on `tick`, latch `ghost_x`/`ghost_y`, `start` = lfsr[1:0], `cnt` = 0, `pass` = 0; go to QUERY.
  - QUERY:
    - Candidate `k` = (`start` + `cnt`) mod 4.
    - If `pass` = 0 and `k` is the reverse: skip. `cnt`++, no `q_valid`. If `cnt` was 3, go to QUERY with `pass` = 1; otherwise stay in QUERY.
    - Otherwise: drive `q_x`/`q_y` for `k`, pulse `q_valid`, go to WAIT.
    - In pass 1 the candidate is always the reverse.
  - WAIT: sample `q_wall`.
    - If free: `nxt` = `k`, go to ISSUE.
    - Else if `pass` = 0 and `cnt` < 3: `cnt`++, go to QUERY.
    - Else if `pass` = 0 and a reverse exists: `pass` = 1, go to QUERY.
    - Else: `nxt` = stop, go to ISSUE.
  - ISSUE: `dir` <= `nxt`, `dir_valid` = 1, go to IDLE.
- **Pass-0 endings:**
  - All non-reverse candidates walled and no reverse exists: result is stop.
  - Pass-0 skip on `cnt` = 3 when no reverse exists cannot occur.
- `tick` arriving while `busy` is dropped and not queued.
- `ghost_x`/`ghost_y` changes after latching are ignored until the next decision.
- `q_x`/`q_y` hold their last value outside QUERY.

## Timing
- **Reset values:** state IDLE; `dir`=0, `dir_valid`=0, `q_valid`=0, `q_x`=0, `q_y`=0, `busy`=0; lfsr = seed.
- `rst` mid-operation abandons the decision: no `dir_valid`, no further `q_valid`.
- With `tick` sampled at edge t:
  - QUERY with `q_valid` high in cycle t+1.
  - WAIT in t+2.
  - Best-case `dir_valid` in t+3.
- **Added latency:**
  - each walled candidate: +2 cycles.
  - reverse skip: +1 cycle.
  - worst case: `dir_valid` at t+10 (3 walled + 1 skip + reverse query).
- `dir` changes only on the `dir_valid` cycle. The mover may sample `dir` at any time.
- `q_valid` is never high on two consecutive cycles.

## Structure
- **Shared `ghost_pkg`:**
  - direction encodings UP/DOWN/LEFT/RIGHT/STOP (same values as the mover uses)
  - `opposite()` function
  - index-to-one-hot function
  - FSM state enum (IDLE, QUERY, WAIT, ISSUE)
- **Sub-module `ghost_lfsr`:** seed parameter, enable, 16-bit state output. Reused by later ghost-AI blocks.

## Test plan
- **Reset:**
  - stimulus: assert `rst` for 2 cycles.
  - response: all outputs 0, `busy`=0, lfsr = 16'hACE1.
- **Open cell:**
  - stimulus: ghost at (8,8), `dir`=0, `q_wall` always 0, `tick`.
  - response: single `q_valid` at t+1 with coordinates equal to the neighbour of lfsr[1:0] from the bench model, e.g. (8,7) for UP; `dir_valid` at t+3 with the matching one-hot.
- **Dead end:**
  - stimulus: `dir`=UP; walls everywhere except (8,9).
  - response: 3 queries, none to (8,9) in pass 0; then a query to (8,9); `dir`=DOWN with `dir_valid` at t+10.
- **Enclosed:**
  - stimulus: all four neighbours walled, `dir`=LEFT.
  - response: 4 queries; `dir`=0 at t+10.
  - stimulus: same with `dir`=0.
  - response: 4 queries; `dir`=0 at t+9.
- **Wrap:**
  - stimulus: ghost at (0,0), LEFT/UP candidate queried.
  - response: `q_x`=63 or `q_y`=63 respectively.
- **Busy and reset:**
  - stimulus: second `tick` while `busy`.
  - response: ignored; exactly one `dir_valid`.
  - stimulus: `rst` during WAIT.
  - response: IDLE next cycle, no `dir_valid`, `dir`=0.
